// File: rtl/npc_pc_regfile_unit_pkg.sv
// Shared widths, reset constants and payload types for the NPC PC/register-file block.
package npc_pc_regfile_unit_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned NREG = 32;
   localparam int unsigned AW   = $clog2(NREG);

   localparam logic [XLEN-1:0] PC_RESET = 64'h0000_0000_8000_0000;
   localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
   localparam logic [AW-1:0]   REG_A0   = 5'd10;
   localparam logic [AW-1:0]   REG_ZERO = 5'd0;

   // Writeback request into the GPR file.
   typedef struct packed {
      logic            wen;
      logic [AW-1:0]   waddr;
      logic [XLEN-1:0] wdata;
   } gpr_wr_t;

endpackage : npc_pc_regfile_unit_pkg

// File: rtl/npc_add64.sv
// Pure combinational 64-bit adder, c = a + b modulo 2^64 (carry-out dropped).
//   a_i  in  XLEN  operand a
//   b_i  in  XLEN  operand b
//   c_o  out XLEN  sum, no carry-out
module npc_add64
   import npc_pc_regfile_unit_pkg::*;
(
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] c_o
);

   assign c_o = a_i + b_i;

endmodule : npc_add64

// File: rtl/npc_pc_regfile_unit.sv
// Architectural state of the single-cycle RV64 NPC core: PC register, PC+4
// incrementer and the 32x64 general-purpose register file.
//   clk       in   1     rising-edge clock
//   rst       in   1     asynchronous active-low reset
//   pc_new    in   XLEN  next PC, loaded every cycle out of reset
//   pc_out    out  XLEN  current PC (registered)
//   pc_plus4  out  XLEN  pc_out + 4 (combinational, wraps)
//   wen/waddr/wdata in  GPR writeback port (writes to x0 dropped)
//   raddr1/raddr2   in  read indices
//   rdata1/rdata2   out GPR reads (combinational, x0 reads as 0, no bypass)
//   a0        out  XLEN  GPR[10] debug tap
module npc_pc_regfile_unit
   import npc_pc_regfile_unit_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_new,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_plus4,
   input  logic            wen,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   output logic [XLEN-1:0] a0
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] gpr_q [NREG];
   gpr_wr_t         wr;
   logic            wr_ok;

   // Next PC is taken unconditionally; there is no stall.
   assign pc_d = pc_new;

   // Bundle writeback; x0 writes are qualified away here.
   always_comb begin
      wr       = '0;
      wr.wen   = wen;
      wr.waddr = waddr;
      wr.wdata = wdata;
      wr_ok    = wr.wen && (wr.waddr != REG_ZERO);
   end

   // PC register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= PC_RESET;
      end else begin
         pc_q <= pc_d;
      end
   end

   // GPR array; entry 0 stays at its reset value since writes to it are dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gpr_q <= '{default: '0};
      end else if (wr_ok) begin
         gpr_q[wr.waddr] <= wr.wdata;
      end
   end

   npc_add64 u_pc_inc (
      .a_i (pc_q),
      .b_i (PC_STEP),
      .c_o (pc_plus4)
   );

   assign pc_out = pc_q;

   // Reads see the pre-edge contents; x0 is forced to zero on the read side.
   assign rdata1 = (raddr1 == REG_ZERO) ? '0 : gpr_q[raddr1];
   assign rdata2 = (raddr2 == REG_ZERO) ? '0 : gpr_q[raddr2];
   assign a0     = gpr_q[REG_A0];

endmodule : npc_pc_regfile_unit

// File: tb/tb_npc_pc_regfile_unit.sv
// Directed self-checking bench for npc_pc_regfile_unit.
module tb_npc_pc_regfile_unit;

   logic        clk;
   logic        rst;
   logic [63:0] pc_new;
   logic [63:0] pc_out;
   logic [63:0] pc_plus4;
   logic        wen;
   logic [4:0]  waddr;
   logic [63:0] wdata;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic [63:0] rdata1;
   logic [63:0] rdata2;
   logic [63:0] a0;

   int n_checks = 0;
   int n_errors = 0;

   npc_pc_regfile_unit dut (
      .clk      (clk),
      .rst      (rst),
      .pc_new   (pc_new),
      .pc_out   (pc_out),
      .pc_plus4 (pc_plus4),
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
      .raddr1   (raddr1),
      .raddr2   (raddr2),
      .rdata1   (rdata1),
      .rdata2   (rdata2),
      .a0       (a0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to the next rising edge and settle just after it.
   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst    = 1'b1;
      pc_new = 64'h1234;
      wen    = 1'b0;
      waddr  = 5'd0;
      wdata  = 64'd0;
      raddr1 = 5'd3;
      raddr2 = 5'd7;

      // 1. Asynchronous reset asserted mid-cycle.
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_pc_out",   pc_out,   64'h8000_0000);
      chk("rst_pc_plus4", pc_plus4, 64'h8000_0004);
      chk("rst_rdata1",   rdata1,   64'd0);
      chk("rst_rdata2",   rdata2,   64'd0);
      chk("rst_a0",       a0,       64'd0);

      // Writes and PC loads ignored while reset is held across an edge.
      wen   = 1'b1;
      waddr = 5'd5;
      wdata = 64'h5555;
      raddr1 = 5'd5;
      edge_settle();
      chk("rst_hold_pc", pc_out, 64'h8000_0000);
      chk("rst_hold_wr", rdata1, 64'd0);

      // 2. Release reset mid-cycle; PC follows pc_new one edge late.
      @(negedge clk);
      wen    = 1'b0;
      rst    = 1'b1;
      pc_new = 64'h8000_0004;
      #1;
      chk("rel_pc_before_edge", pc_out, 64'h8000_0000);
      chk("rel_no_wr_in_rst",   rdata1, 64'd0);
      edge_settle();
      chk("pc_step1",     pc_out,   64'h8000_0004);
      chk("pc_step1_p4",  pc_plus4, 64'h8000_0008);
      @(negedge clk);
      pc_new = 64'h8000_0100;
      #1;
      chk("pc_hold_pre_edge", pc_out, 64'h8000_0004);
      edge_settle();
      chk("pc_step2",     pc_out,   64'h8000_0100);
      chk("pc_step2_p4",  pc_plus4, 64'h8000_0104);

      // 3. Write x5; no bypass before the edge.
      @(negedge clk);
      wen    = 1'b1;
      waddr  = 5'd5;
      wdata  = 64'hDEAD_BEEF_0000_0001;
      raddr1 = 5'd5;
      raddr2 = 5'd5;
      #1;
      chk("x5_pre_edge", rdata1, 64'd0);
      edge_settle();
      chk("x5_post_edge",  rdata1, 64'hDEAD_BEEF_0000_0001);
      chk("x5_same_port2", rdata2, 64'hDEAD_BEEF_0000_0001);

      // 4. Write to x0 discarded.
      @(negedge clk);
      waddr  = 5'd0;
      wdata  = 64'hFFFF_FFFF_FFFF_FFFF;
      raddr1 = 5'd0;
      edge_settle();
      chk("x0_read_zero", rdata1, 64'd0);
      chk("x5_intact",    rdata2, 64'hDEAD_BEEF_0000_0001);

      // 5. a0 tap.
      @(negedge clk);
      waddr  = 5'd10;
      wdata  = 64'h2A;
      raddr2 = 5'd10;
      #1;
      chk("a0_pre_edge", a0, 64'd0);
      edge_settle();
      chk("a0_written",   a0,     64'h2A);
      chk("x10_rdata2",   rdata2, 64'h2A);
      @(negedge clk);
      wen   = 1'b0;
      waddr = 5'd10;
      wdata = 64'h99;
      edge_settle();
      chk("a0_wen0_hold", a0,     64'h2A);
      chk("x10_wen0",     rdata2, 64'h2A);

      // 6. PC+4 wraps to zero.
      @(negedge clk);
      pc_new = 64'hFFFF_FFFF_FFFF_FFFC;
      edge_settle();
      chk("wrap_pc",     pc_out,   64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_plus4",  pc_plus4, 64'd0);

      // Asynchronous reset with registers loaded.
      raddr1 = 5'd5;
      raddr2 = 5'd10;
      #2;
      chk("preload_x5", rdata1, 64'hDEAD_BEEF_0000_0001);
      rst = 1'b0;
      #1;
      chk("rst2_rdata1", rdata1, 64'd0);
      chk("rst2_rdata2", rdata2, 64'd0);
      chk("rst2_a0",     a0,     64'd0);
      chk("rst2_pc",     pc_out, 64'h8000_0000);
      chk("rst2_p4",     pc_plus4, 64'h8000_0004);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_npc_pc_regfile_unit
